// File: rtl/tlb_cp0_unit.sv
// CP0 TLB register file (Index/EntryHi/EntryLo0/EntryLo1/Random) with a
// two-state sequencer that runs TLBP/TLBR/TLBWI/TLBWR against an external TLB.
module tlb_cp0_unit #(
  parameter int TLB_NUM = 16,
  localparam int IW = $clog2(TLB_NUM)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  output logic          op_done,
  input  logic          mtc0_we,
  input  logic [1:0]    mtc0_sel,
  input  logic [31:0]   mtc0_data,
  output logic [31:0]   index_q,
  output logic [31:0]   entryhi_q,
  output logic [31:0]   entrylo0_q,
  output logic [31:0]   entrylo1_q,
  output logic [31:0]   random_q,
  output logic [18:0]   s_vpn2,
  output logic          s_odd_page,
  output logic [7:0]    s_asid,
  input  logic          s_found,
  input  logic [IW-1:0] s_index,
  output logic          w_en,
  output logic [IW-1:0] w_index,
  output logic [77:0]   w_entry,
  output logic [IW-1:0] r_index,
  input  logic [77:0]   r_entry
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  localparam logic [1:0]    OP_TLBP  = 2'b00;
  localparam logic [1:0]    OP_TLBR  = 2'b01;
  localparam logic [1:0]    OP_TLBWI = 2'b10;
  localparam logic [1:0]    OP_TLBWR = 2'b11;
  localparam logic [IW-1:0] RAND_MAX = IW'(TLB_NUM - 1);

  state_t        state_r;
  logic          op_done_r;
  logic [1:0]    op_code_r;
  logic [IW-1:0] rand_idx_r;
  logic [IW-1:0] random_r;
  logic          index_p_r;
  logic [IW-1:0] index_idx_r;
  logic [18:0]   ehi_vpn2_r;
  logic [7:0]    ehi_asid_r;
  // EntryLo fields stored as {pfn[19:0], c[2:0], d, v, g}, matching bits [25:0]
  logic [25:0]   lo0_r;
  logic [25:0]   lo1_r;
  logic          unused_s;

  assign unused_s = ^mtc0_data;

  // Sequencer, CP0 register updates and free-running Random counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      op_done_r   <= 1'b0;
      op_code_r   <= 2'b00;
      rand_idx_r  <= {IW{1'b0}};
      random_r    <= RAND_MAX;
      index_p_r   <= 1'b0;
      index_idx_r <= {IW{1'b0}};
      ehi_vpn2_r  <= 19'd0;
      ehi_asid_r  <= 8'd0;
      lo0_r       <= 26'd0;
      lo1_r       <= 26'd0;
    end else begin
      random_r  <= (random_r == {IW{1'b0}}) ? RAND_MAX : random_r - IW'(1);
      op_done_r <= 1'b0;
      if (mtc0_we) begin
        case (mtc0_sel)
          2'd0:    index_idx_r <= mtc0_data[IW-1:0];
          2'd1:    begin
                     ehi_vpn2_r <= mtc0_data[31:13];
                     ehi_asid_r <= mtc0_data[7:0];
                   end
          2'd2:    lo0_r <= mtc0_data[25:0];
          2'd3:    lo1_r <= mtc0_data[25:0];
          default: lo1_r <= lo1_r;
        endcase
      end
      // Op results are assigned after mtc0 so they win on a same-cycle collision
      case (state_r)
        IDLE: begin
          if (op_valid) begin
            state_r    <= EXEC;
            op_code_r  <= op_code;
            rand_idx_r <= random_r;
          end
        end
        EXEC: begin
          state_r   <= IDLE;
          op_done_r <= 1'b1;
          case (op_code_r)
            OP_TLBP: begin
              if (s_found) begin
                index_p_r   <= 1'b0;
                index_idx_r <= s_index;
              end else begin
                index_p_r <= 1'b1;
              end
            end
            OP_TLBR: begin
              ehi_vpn2_r <= r_entry[77:59];
              ehi_asid_r <= r_entry[58:51];
              lo0_r      <= {r_entry[49:25], r_entry[50]};
              lo1_r      <= {r_entry[24:0], r_entry[50]};
            end
            default: index_p_r <= index_p_r;
          endcase
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign op_ready   = (state_r == IDLE);
  assign op_done    = op_done_r;
  assign index_q    = {index_p_r, {(31-IW){1'b0}}, index_idx_r};
  assign entryhi_q  = {ehi_vpn2_r, 5'd0, ehi_asid_r};
  assign entrylo0_q = {6'd0, lo0_r};
  assign entrylo1_q = {6'd0, lo1_r};
  assign random_q   = {{(32-IW){1'b0}}, random_r};

  assign s_vpn2     = ehi_vpn2_r;
  assign s_asid     = ehi_asid_r;
  assign s_odd_page = 1'b0;

  assign r_index = index_idx_r;
  assign w_en    = (state_r == EXEC) && (op_code_r == OP_TLBWI || op_code_r == OP_TLBWR);
  assign w_index = (op_code_r == OP_TLBWR) ? rand_idx_r : index_idx_r;
  assign w_entry = {ehi_vpn2_r, ehi_asid_r, lo0_r[0] & lo1_r[0], lo0_r[25:1], lo1_r[25:1]};

endmodule

// File: tb/tb_tlb_cp0_unit.sv
// Directed self-checking bench for tlb_cp0_unit (TLB_NUM = 16).
module tb_tlb_cp0_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_ready;
  logic        op_done;
  logic        mtc0_we;
  logic [1:0]  mtc0_sel;
  logic [31:0] mtc0_data;
  logic [31:0] index_q, entryhi_q, entrylo0_q, entrylo1_q, random_q;
  logic [18:0] s_vpn2;
  logic        s_odd_page;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic        w_en;
  logic [3:0]  w_index;
  logic [77:0] w_entry;
  logic [3:0]  r_index;
  logic [77:0] r_entry;

  int checks = 0;
  int errors = 0;

  tlb_cp0_unit #(.TLB_NUM(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready), .op_done(op_done),
    .mtc0_we(mtc0_we), .mtc0_sel(mtc0_sel), .mtc0_data(mtc0_data),
    .index_q(index_q), .entryhi_q(entryhi_q), .entrylo0_q(entrylo0_q),
    .entrylo1_q(entrylo1_q), .random_q(random_q),
    .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index),
    .w_en(w_en), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mtc0(input logic [1:0] sel, input logic [31:0] data);
    mtc0_we = 1'b1; mtc0_sel = sel; mtc0_data = data;
    step();
    mtc0_we = 1'b0; mtc0_data = 32'h0;
  endtask

  // Accept an op, scramble op_code during EXEC, return at N+2
  task automatic run_op(input logic [1:0] code);
    op_valid = 1'b1; op_code = code;
    step();
    op_valid = 1'b0; op_code = ~code;
    step();
  endtask

  logic [77:0] exp_w;
  logic [77:0] rd_entry;
  int guard;

  initial begin
    reset_n = 1'b0; op_valid = 1'b0; op_code = 2'b00; mtc0_we = 1'b0;
    mtc0_sel = 2'd0; mtc0_data = 32'h0; s_found = 1'b0; s_index = 4'd0;
    r_entry = 78'd0;
    repeat (2) step();
    chk("rst_random", random_q, 78'd15);
    chk("rst_index", index_q, 78'd0);
    chk("rst_w_en", w_en, 78'd0);
    chk("rst_op_done", op_done, 78'd0);
    reset_n = 1'b1;
    chk("first_op_ready", op_ready, 78'd1);
    chk("random_start", random_q, 78'd15);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("random_seq", random_q, 78'((14 - i + 16) % 16));
    end

    // Field masks on mtc0 writes
    mtc0(2'd1, 32'hFFFF_FFFF);
    chk("ehi_mask", entryhi_q, 78'h0000_0000_FFFF_E0FF);
    mtc0(2'd2, 32'hFFFF_FFFF);
    chk("lo0_mask", entrylo0_q, 78'h03FF_FFFF);
    mtc0(2'd0, 32'hFFFF_FFFF);
    chk("index_mask", index_q, 78'h0000_000F);

    // TLBWI
    mtc0(2'd1, 32'h0000_2005);
    mtc0(2'd2, 32'h0000_0047);
    mtc0(2'd3, 32'h0000_0087);
    mtc0(2'd0, 32'h0000_0003);
    chk("ehi_val", entryhi_q, 78'h2005);
    chk("s_vpn2", s_vpn2, 78'd1);
    chk("s_asid", s_asid, 78'd5);
    chk("s_odd", s_odd_page, 78'd0);
    exp_w = {19'd1, 8'd5, 1'b1, 20'd1, 3'd0, 1'b1, 1'b1, 20'd2, 3'd0, 1'b1, 1'b1};
    chk("wi_idle_w_en", w_en, 78'd0);
    op_valid = 1'b1; op_code = 2'b10;
    step();
    op_valid = 1'b0; op_code = 2'b00;
    chk("wi_w_en", w_en, 78'd1);
    chk("wi_w_index", w_index, 78'd3);
    chk("wi_w_entry", w_entry, exp_w);
    chk("wi_ready_exec", op_ready, 78'd0);
    chk("wi_done_early", op_done, 78'd0);
    step();
    chk("wi_w_en_off", w_en, 78'd0);
    chk("wi_done", op_done, 78'd1);
    chk("wi_ready", op_ready, 78'd1);
    step();
    chk("wi_done_pulse", op_done, 78'd0);

    // TLBP hit then miss
    mtc0(2'd0, 32'h0000_000A);
    s_found = 1'b1; s_index = 4'd3;
    run_op(2'b00);
    chk("p_hit_done", op_done, 78'd1);
    chk("p_hit", index_q, 78'h0000_0003);
    s_found = 1'b0; s_index = 4'd9;
    run_op(2'b00);
    chk("p_miss", index_q, 78'h8000_0003);

    // TLBR
    mtc0(2'd0, 32'h0000_0007);
    chk("r_index", r_index, 78'd7);
    rd_entry = {19'h5A5A5, 8'h12, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b0, 20'hABCDE, 3'd5, 1'b0, 1'b1};
    r_entry = rd_entry;
    run_op(2'b01);
    r_entry = 78'd0;
    chk("r_ehi", entryhi_q, 78'({19'h5A5A5, 5'd0, 8'h12}));
    chk("r_lo0", entrylo0_q, 78'({6'd0, 20'h12345, 3'd3, 1'b1, 1'b0, 1'b0}));
    chk("r_lo1", entrylo1_q, 78'({6'd0, 20'hABCDE, 3'd5, 1'b0, 1'b1, 1'b0}));

    // TLBWR at random == 4; entries now mirror what TLBR loaded
    guard = 0;
    while (random_q !== 32'd4 && guard < 40) begin
      step();
      guard++;
    end
    chk("rand_reach4", random_q, 78'd4);
    op_valid = 1'b1; op_code = 2'b11;
    step();
    op_valid = 1'b0;
    chk("wr_w_en", w_en, 78'd1);
    chk("wr_w_index", w_index, 78'd4);
    chk("wr_w_entry", w_entry, rd_entry);
    step();
    chk("wr_done", op_done, 78'd1);

    // Held op_valid, mtc0 collision in EXEC
    s_found = 1'b1; s_index = 4'd2;
    op_valid = 1'b1; op_code = 2'b00;
    step();
    chk("hold_exec_ready", op_ready, 78'd0);
    mtc0_we = 1'b1; mtc0_sel = 2'd0; mtc0_data = 32'd9;
    step();
    mtc0_we = 1'b0;
    chk("collide_index", index_q, 78'd2);
    chk("hold_done", op_done, 78'd1);
    chk("hold_ready", op_ready, 78'd1);
    step();
    op_valid = 1'b0;
    chk("hold_second_exec", op_ready, 78'd0);
    chk("hold_done_clr", op_done, 78'd0);
    step();
    chk("hold_second_done", op_done, 78'd1);
    s_found = 1'b0;

    // Reset during EXEC
    op_valid = 1'b1; op_code = 2'b10;
    step();
    op_valid = 1'b0;
    chk("abort_w_en_pre", w_en, 78'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_w_en", w_en, 78'd0);
    chk("abort_ready", op_ready, 78'd1);
    chk("abort_index", index_q, 78'd0);
    chk("abort_ehi", entryhi_q, 78'd0);
    chk("abort_lo0", entrylo0_q, 78'd0);
    chk("abort_lo1", entrylo1_q, 78'd0);
    chk("abort_random", random_q, 78'd15);
    step();
    chk("abort_no_done", op_done, 78'd0);
    reset_n = 1'b1;
    step();
    chk("abort_no_done2", op_done, 78'd0);
    chk("abort_ready2", op_ready, 78'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_cp0_unit.md
TLB_CP0_UNIT -- requirements
Module: tlb_cp0_unit

Interface
REQ-001 SHALL have parameter TLB_NUM, default 16, meaning number of TLB entries; IW = $clog2(TLB_NUM).
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port op_valid  in  1  TLB instruction request.
REQ-005 SHALL have port op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR.
REQ-006 SHALL have port op_ready  out  1  unit idle, can accept an op.
REQ-007 SHALL have port op_done  out  1  one-cycle completion pulse.
REQ-008 SHALL have port mtc0_we  in  1  CP0 register write strobe.
REQ-009 SHALL have port mtc0_sel  in  2  0 Index, 1 EntryHi, 2 EntryLo0, 3 EntryLo1.
REQ-010 SHALL have port mtc0_data  in  32  CP0 write data.
REQ-011 SHALL have ports index_q, entryhi_q, entrylo0_q, entrylo1_q, random_q  out  32 each  CP0 register values.
REQ-012 SHALL have port s_vpn2  out  19, s_odd_page  out  1, s_asid  out  8  TLB search request.
REQ-013 SHALL have port s_found  in  1, s_index  in  IW  TLB search result, combinational same cycle.
REQ-014 SHALL have port w_en  out  1, w_index  out  IW, w_entry  out  78  TLB write port.
REQ-015 SHALL have port r_index  out  IW, r_entry  in  78  TLB read port, combinational.
REQ-016 SHALL pack w_entry/r_entry MSB-first as {vpn2[19], asid[8], g, pfn0[20], c0[3], d0, v0, pfn1[20], c1[3], d1, v1}.

Function
REQ-017 SHALL implement FSM IDLE/EXEC; op_ready = (state==IDLE); op_valid&&op_ready moves to EXEC, latching op_code and, for TLBWR, random index.
REQ-018 SHALL perform the op during the single EXEC cycle, return to IDLE next edge, and assert op_done (registered) exactly that next cycle; accept at N -> op_done at N+2, op_ready high at N+2.
REQ-019 SHALL format EntryHi as VPN2[31:13], ASID[7:0], others read 0; EntryLo as PFN[25:6], C[5:3], D[2], V[1], G[0], [31:26] read 0; Index as P[31], index[IW-1:0], others read 0.
REQ-020 SHALL drive s_vpn2/s_asid from EntryHi and s_odd_page=0 continuously.
REQ-021 TLBP SHALL, at EXEC end, set Index = {P=0, s_index} on s_found=1, else P=1 with index field unchanged.
REQ-022 TLBR SHALL drive r_index = Index.index continuously and at EXEC end load EntryHi.VPN2/ASID, EntryLo0, EntryLo1 from r_entry, G bit of both EntryLo = r_entry.g.
REQ-023 TLBWI/TLBWR SHALL assert w_en only in EXEC, w_index = Index.index (TLBWI) or latched random (TLBWR), w_entry from registers with g = EntryLo0.G & EntryLo1.G.
REQ-024 w_en SHALL be 0 in all other cycles; w_index/w_entry SHALL remain defined values.
REQ-025 random_q[IW-1:0] SHALL decrement every cycle, wrapping 0 -> TLB_NUM-1; upper bits 0; not software-writable.
REQ-026 mtc0_we SHALL update the selected register at clock edge, writing only defined fields; Index.P not writable by mtc0.
REQ-027 SHALL apply mtc0_we in any state; if it targets a register updated by an op in the same EXEC cycle, the op result SHALL win.
REQ-028 SHALL ignore op_valid while not op_ready; op_code SHALL need to be stable only in the accept cycle.

Reset
REQ-029 On reset_n low, immediately: state IDLE, op_done 0, w_en 0, Index/EntryHi/EntryLo0/EntryLo1 0, random = TLB_NUM-1.
REQ-030 Reset during EXEC SHALL abort the op: no op_done, no further register update, w_en deasserted asynchronously.
REQ-031 op_ready SHALL be 1 on the first cycle after reset_n deasserts.

Verification
REQ-032 mtc0 EntryHi=0x0000_2005, EntryLo0=0x0000_0047, EntryLo1=0x0000_0087, Index=3; TLBWI -> w_en one cycle, w_index 3, vpn2 1, asid 5, g 1, pfn0 1, c0 0, d0 1, v0 1, pfn1 2; op_done at N+2.
REQ-033 TLBP with s_found=1, s_index=3 -> index_q=0x0000_0003; with s_found=0 -> index_q=0x8000_0003.
REQ-034 Index=7, r_entry g=0, asid 0x12, pfn1 0xABCDE; TLBR -> entryhi_q[7:0]=0x12, entrylo1_q[25:6]=0xABCDE, both G=0.
REQ-035 After reset, random_q = 15,14,...,0,15 on consecutive cycles; TLBWR accepted when random=4 -> w_index=4.
REQ-036 op_valid held during EXEC -> second op accepted only at N+2; mtc0 Index=9 during TLBP EXEC with hit index 2 -> index_q=2; reset_n pulsed in EXEC -> no op_done, all registers 0.
